sprom_arbiter: RTL and testbench

//  Shares one synchronous single-port ROM (registered address, data valid the

---
 rtl/sprom_arbiter.sv | 137 +++++++++++++
 tb/tb_sprom_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprom_arbiter.sv
// Shares one registered-address single-port ROM among NREQ requesters, with burst locking.
// Define SPROM_ARB_RR_EN for round-robin arbitration; otherwise index 0 has fixed highest priority.
module sprom_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 10,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [2:0]         owner,
  output logic               locked,
  output logic               rom_ce,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_do
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t          state_reg;
  logic [IW-1:0]   owner_reg;
  logic            s1_v_reg;
  logic [IW-1:0]   s1_id_reg;
  logic [NREQ-1:0] rvalid_reg;
  logic [DW-1:0]   rdata_reg;

  logic            win_any;
  logic [IW-1:0]   win_id;
  logic            grant_v;
  logic [IW-1:0]   grant_id;

`ifdef SPROM_ARB_RR_EN
  logic [IW-1:0]   ptr_reg;
  int              idx;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] w);
    return (w == IW'(NREQ - 1)) ? '0 : w + 1'b1;
  endfunction

  // Scan offsets from the far end so the requester nearest the pointer wins.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        win_any = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end
`else
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_any = 1'b1;
        win_id  = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    if (state_reg == ST_LOCKED) begin
      grant_v  = req[owner_reg];
      grant_id = owner_reg;
    end else begin
      grant_v  = win_any;
      grant_id = win_id;
    end
  end

  assign gnt      = grant_v ? (NREQ'(1) << grant_id) : '0;
  assign rom_ce   = grant_v;
  assign rom_addr = grant_v ? addr[grant_id*AW +: AW] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_ARB;
      owner_reg  <= '0;
      s1_v_reg   <= 1'b0;
      s1_id_reg  <= '0;
      rvalid_reg <= '0;
      rdata_reg  <= '0;
`ifdef SPROM_ARB_RR_EN
      ptr_reg    <= '0;
`endif
    end else begin
      s1_v_reg   <= grant_v;
      s1_id_reg  <= grant_id;
      rvalid_reg <= s1_v_reg ? (NREQ'(1) << s1_id_reg) : '0;
      if (s1_v_reg) rdata_reg <= rom_do;

      case (state_reg)
        ST_ARB: begin
          if (grant_v) begin
`ifdef SPROM_ARB_RR_EN
            ptr_reg <= next_idx(grant_id);
`endif
            if (lock[grant_id]) begin
              state_reg <= ST_LOCKED;
              owner_reg <= grant_id;
            end
          end
        end
        default: begin
          // Dropping lock ends the burst whether or not the owner is requesting.
          if (!lock[owner_reg]) begin
            state_reg <= ST_ARB;
`ifdef SPROM_ARB_RR_EN
            if (req[owner_reg]) ptr_reg <= next_idx(owner_reg);
`endif
          end
        end
      endcase
    end
  end

  assign rvalid = rvalid_reg;
  assign rdata  = rdata_reg;
  assign locked = (state_reg == ST_LOCKED);
  assign owner  = 3'(owner_reg);

endmodule

// File: tb/tb_sprom_arbiter.sv
// Self-checking bench for sprom_arbiter: per-cycle model comparison plus directed scenarios.
module tb_sprom_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    lock = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [2:0]         owner;
  logic               locked;
  logic               rom_ce;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_do = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  sprom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .owner(owner), .locked(locked),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_do(rom_do)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
    mem[5] = 32'h0000_A5A5;
  end

  // Synchronous ROM: data for the address registered with rom_ce appears next cycle.
  always @(posedge clk) if (rom_ce) rom_do <= mem[rom_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: arbitration state plus a two-stage delay queue of granted reads.
  logic            m_locked = 1'b0;
  int              m_owner = 0;
  int              m_ptr = 0;
  int              m_start;
  int              m_idx;
  logic            m_s1v = 1'b0;
  int              m_s1id = 0;
  logic [AW-1:0]   m_s1a = '0;
  logic [NREQ-1:0] m_rv = '0;
  logic [DW-1:0]   m_rd = '0;
  int              e_w;
  logic [NREQ-1:0] e_gnt;
  logic [AW-1:0]   e_addr;

  always @(negedge clk) begin
    cyc++;
    e_w = -1;
`ifdef SPROM_ARB_RR_EN
    m_start = m_ptr;
`else
    m_start = 0;
`endif
    if (m_locked) begin
      if (req[m_owner]) e_w = m_owner;
    end else begin
      for (int off = 0; off < NREQ; off++) begin
        m_idx = (m_start + off) % NREQ;
        if (e_w < 0 && req[m_idx]) e_w = m_idx;
      end
    end
    e_gnt  = (e_w >= 0) ? NREQ'(1 << e_w) : '0;
    e_addr = (e_w >= 0) ? addr[e_w*AW +: AW] : '0;

    check("gnt", gnt, e_gnt);
    check("rom_ce", rom_ce, e_w >= 0);
    check("rom_addr", rom_addr, e_addr);
    check("rvalid", rvalid, m_rv);
    check("locked", locked, m_locked);
    check("owner", owner, m_owner);
    if (m_rv != 0) check("rdata", rdata, m_rd);
    if (gnt != 0 || rvalid != 0)
      $display("cyc %0d rst=%b req=%b gnt=%b rom_addr=%0d rvalid=%b rdata=%h locked=%b owner=%0d",
               cyc, rst, req, gnt, rom_addr, rvalid, rdata, locked, owner);

    if (rst) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = 0;
      m_s1v = 1'b0; m_s1id = 0; m_s1a = '0; m_rv = '0; m_rd = '0;
    end else begin
      m_rv = m_s1v ? NREQ'(1 << m_s1id) : '0;
      if (m_s1v) m_rd = mem[m_s1a];
      m_s1v  = (e_w >= 0);
      m_s1id = (e_w >= 0) ? e_w : 0;
      m_s1a  = e_addr;
      if (m_locked) begin
        if (!lock[m_owner]) begin
          m_locked = 1'b0;
          if (e_w >= 0) m_ptr = (e_w + 1) % NREQ;
        end
      end else if (e_w >= 0) begin
        m_ptr = (e_w + 1) % NREQ;
        if (lock[e_w]) begin
          m_locked = 1'b1;
          m_owner  = e_w;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] exp_g;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset_rvalid", rvalid, 4'b0000);
    check("reset_rdata", rdata, 32'h0);
    check("reset_locked", locked, 1'b0);
    check("reset_owner", owner, 3'd0);
    tick();

    // Single read of ROM[5]
    req = 4'b0001; addr[0 +: AW] = 10'd5;
    #1 check("t1_gnt", gnt, 4'b0001);
    check("t1_rom_addr", rom_addr, 10'd5);
    tick();
    req = 4'b0000;
    #1 check("t1_idle_gnt", gnt, 4'b0000);
    tick();
    #1 check("t1_rvalid", rvalid, 4'b0001);
    check("t1_rdata", rdata, 32'h0000_A5A5);
    tick();
    #1 check("t1_rvalid_one_cycle", rvalid, 4'b0000);

    // Contention from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = AW'(100 + k*4 + i);
`ifdef SPROM_ARB_RR_EN
      exp_g = 4'b0001 << (k % 4);
`else
      exp_g = 4'b0001;
`endif
      #1 check("t2_order", gnt, exp_g);
      tick();
    end
    req = 4'b1110;
    #1 check("t2_req0_drop", gnt, 4'b0010);
    tick();
    req = 4'b0000;
    tick();

    // Back-to-back reads by requester 2
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        req = 4'b0100;
        addr[2*AW +: AW] = AW'(10 + k);
      end else begin
        req = 4'b0000;
      end
      #1;
      if (k < 3) check("t3_gnt", gnt, 4'b0100);
      if (k >= 2) begin
        check("t3_rvalid", rvalid, 4'b0100);
        check("t3_rdata", rdata, mem[10 + k - 2]);
      end
      tick();
    end

    // Lock burst by requester 1 while requester 0 waits
    addr[0 +: AW] = 10'd30;
    for (int k = 0; k < 5; k++) begin
      addr[1*AW +: AW] = AW'(20 + k);
      if (k < 4) begin
        req  = (k == 0) ? 4'b0010 : 4'b0011;
        lock = (k == 3) ? 4'b0000 : 4'b0010;
      end else begin
        req  = 4'b0001;
        lock = 4'b0000;
      end
      #1;
      if (k < 4) begin
        check("t4_burst_gnt", gnt, 4'b0010);
        check("t4_locked", locked, k > 0);
        if (k > 0) check("t4_owner", owner, 3'd1);
      end else begin
        check("t4_release_gnt", gnt, 4'b0001);
        check("t4_unlocked", locked, 1'b0);
      end
      tick();
    end
    req = 4'b0000;
    tick();

    // Idle hold by owner 3
    for (int k = 0; k < 6; k++) begin
      req  = (k == 0) ? 4'b1000 : 4'b0001;
      lock = (k < 4) ? 4'b1000 : 4'b0000;
      #1;
      if (k == 0) check("t5_lock_gnt", gnt, 4'b1000);
      else if (k < 4) begin
        check("t5_hold_gnt", gnt, 4'b0000);
        check("t5_hold_locked", locked, 1'b1);
        check("t5_hold_owner", owner, 3'd3);
      end else if (k == 4) check("t5_drop_gnt", gnt, 4'b0000);
      else begin
        check("t5_after_gnt", gnt, 4'b0001);
        check("t5_after_locked", locked, 1'b0);
      end
      tick();
    end
    req = 4'b0000;
    tick();

    // Reset with two reads in flight
    req = 4'b0100; lock = 4'b0000; addr[2*AW +: AW] = 10'd7;
    #1 check("t6_gnt_t", gnt, 4'b0100);
    tick();
    rst = 1'b1; lock = 4'b0100; addr[2*AW +: AW] = 10'd8;
    tick();
    rst = 1'b0; req = 4'b0000; lock = 4'b0000;
    #1 check("t6_rvalid_t2", rvalid, 4'b0000);
    check("t6_locked", locked, 1'b0);
    tick();
    req = 4'b1001;
    #1 check("t6_rvalid_t3", rvalid, 4'b0000);
    check("t6_post_reset_gnt", gnt, 4'b0001);
    tick();
    req = 4'b0000;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
